// File: rtl/mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier controller: state encoding,
// registered output bundle and the counter-width helper.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        STEP  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic init;
        logic sr;
        logic busy;
        logic done;
        logic add_en;
    } ctrl_t;

    function automatic int calc_cw(input int width);
        if (width < 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

    // add_en is only a gate; the Mealy add output ANDs it with q0
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            INIT: begin
                c.init = 1'b1;
                c.busy = 1'b1;
            end
            STEP: begin
                c.sr     = 1'b1;
                c.busy   = 1'b1;
                c.add_en = 1'b1;
            end
            ADD: begin
                c.busy   = 1'b1;
                c.add_en = 1'b1;
            end
            SHIFT: begin
                c.sr   = 1'b1;
                c.busy = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Iteration down-counter: load, decrement-enable and zero flag.
module mult_step_counter
    import mult_ctrl_pkg::*;
#(
    parameter int              CW       = 2,
    parameter logic [CW-1:0]   LOAD_VAL = {CW{1'b1}}
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    // count register; saturates at zero so a stray dec cannot wrap
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= {CW{1'b0}};
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != {CW{1'b0}})) begin
            count <= count - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

    assign zero = (count == {CW{1'b0}});

endmodule

// File: rtl/shift_add_mult_controller.sv
// Control FSM for a sequential shift-add multiplier: start/done handshake,
// LSB-conditional add, one- or two-cycle-per-bit schedule.
module shift_add_mult_controller
    import mult_ctrl_pkg::*;
#(
    parameter int   WIDTH     = 4,
    parameter bit   SPLIT_ADD = 1'b0,
    localparam int  CW        = calc_cw(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          q0,
    output logic          init,
    output logic          add,
    output logic          SR,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] step
);

    state_t          state_r;
    state_t          state_nxt_s;
    ctrl_t           ctrl_r;
    logic            cnt_load_s;
    logic            cnt_dec_s;
    logic            cnt_zero_s;
    logic [CW-1:0]   cnt_s;

    // next-state logic and iteration counter control
    always_comb begin
        state_nxt_s = IDLE;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = INIT;
                    cnt_load_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT: begin
                state_nxt_s = SPLIT_ADD ? ADD : STEP;
            end
            STEP: begin
                if (cnt_zero_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = STEP;
                    cnt_dec_s   = 1'b1;
                end
            end
            ADD: begin
                state_nxt_s = SHIFT;
            end
            SHIFT: begin
                if (cnt_zero_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                    cnt_dec_s   = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = INIT;
                    cnt_load_s  = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // state and output registers; outputs decoded from the next state so
    // they change on the same edge as the state itself
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            ctrl_r  <= decode_state(state_nxt_s);
        end
    end

    mult_step_counter #(
        .CW       (CW),
        .LOAD_VAL (CW'(WIDTH - 1))
    ) u_step_counter (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load_s),
        .dec   (cnt_dec_s),
        .count (cnt_s),
        .zero  (cnt_zero_s)
    );

    assign init = ctrl_r.init;
    assign SR   = ctrl_r.sr;
    assign busy = ctrl_r.busy;
    assign done = ctrl_r.done;
    assign add  = ctrl_r.add_en & q0;
    assign step = cnt_s;

endmodule

// File: tb/tb_shift_add_mult_controller.sv
// Scoreboard bench: three controller configurations driving behavioural
// datapaths, checked cycle by cycle against a timeline model.
module tb_shift_add_mult_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        fin_chk;
    logic [31:0] ra [3];
    logic [31:0] rb [3];

    logic        init_a [3];
    logic        add_a  [3];
    logic        sr_a   [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic        q0_a   [3];
    logic [7:0]  step_a [3];

    int          t_a [3] = '{-1, -1, -1};
    logic [31:0] ca  [3];
    logic [16:0] p_a [3];
    logic [7:0]  m_a [3];
    int          exp_q [3][$];
    logic        armed = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    function automatic int wof(input int i);
        return (i == 2) ? 8 : 4;
    endfunction

    function automatic int sof(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int lof(input int i);
        return (sof(i) == 1) ? 2 * wof(i) : wof(i);
    endfunction

    function automatic logic [16:0] dp_next(input logic [16:0] p, input logic [7:0] m,
                                            input logic ld, input logic ad, input logic sr,
                                            input logic [31:0] b, input int w);
        logic [16:0] r;
        r = p;
        if (ld) begin
            r = 17'(b);
        end else begin
            if (ad) r = r + (17'(m) << w);
            if (sr) r = r >> 1;
        end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GW = (g == 2) ? 8 : 4;
        localparam bit GS = (g == 1) ? 1'b1 : 1'b0;
        logic [$clog2(GW)-1:0] st;

        shift_add_mult_controller #(.WIDTH(GW), .SPLIT_ADD(GS)) u_dut (
            .clock (clk),
            .reset (rst),
            .start (start),
            .q0    (q0_a[g]),
            .init  (init_a[g]),
            .add   (add_a[g]),
            .SR    (sr_a[g]),
            .busy  (busy_a[g]),
            .done  (done_a[g]),
            .step  (st)
        );

        assign step_a[g] = 8'(st);
        assign q0_a[g]   = p_a[g][0];
    end

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[cfg%0d] @%0t got=%0d expected=%0d", nm, idx, $time, act, exp);
        end
    endtask

    // reference timeline + behavioural datapath, advanced on each rising edge
    initial begin : model
        forever begin
            @(posedge clk);
            armed <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin
                    t_a[i] <= -1;
                    exp_q[i].delete();
                end else if (start && (t_a[i] < 0 || t_a[i] >= lof(i) + 2)) begin
                    t_a[i] <= 1;
                    ca[i]  <= ra[i];
                    exp_q[i].push_back(int'(ra[i] * rb[i]));
                end else if (t_a[i] >= 0 && t_a[i] < lof(i) + 2) begin
                    t_a[i] <= t_a[i] + 1;
                end else begin
                    t_a[i] <= t_a[i];
                end
                p_a[i] <= dp_next(p_a[i], m_a[i], init_a[i], add_a[i], sr_a[i], rb[i], wof(i));
                if (init_a[i]) m_a[i] <= ca[i][7:0];
            end
        end
    end

    // monitor: per-cycle output checks and product pop on done rising
    initial begin : monitor
        logic done_prev [3];
        int   w, s, l, t, j, e_step;
        logic e_init, e_busy, e_done, e_sr, e_add, work;
        done_prev = '{1'b0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < 3; i++) begin
                    w = wof(i); s = sof(i); l = lof(i); t = t_a[i]; j = t - 2;
                    work   = (t >= 2) && (t <= l + 1);
                    e_init = (t == 1);
                    e_busy = (t >= 1) && (t <= l + 1);
                    e_done = (t >= l + 2);
                    e_sr   = work && ((s == 0) || (j % 2 == 1));
                    e_add  = work && ((s == 0) || (j % 2 == 0)) && q0_a[i];
                    e_step = (t == 1) ? w - 1 : (work ? w - 1 - ((s == 1) ? j / 2 : j) : 0);
                    chk("init", i, init_a[i], e_init);
                    chk("busy", i, busy_a[i], e_busy);
                    chk("done", i, done_a[i], e_done);
                    chk("SR",   i, sr_a[i],   e_sr);
                    chk("add",  i, add_a[i],  e_add);
                    chk("step", i, step_a[i], e_step);
                    if (done_a[i] && !done_prev[i]) begin
                        chk("pending_op", i, exp_q[i].size() > 0, 1);
                        if (exp_q[i].size() > 0) chk("product", i, p_a[i], exp_q[i].pop_front());
                    end
                    if (fin_chk) chk("queue_drained", i, exp_q[i].size(), 0);
                    done_prev[i] = done_a[i];
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_ops(input logic [31:0] a4, input logic [31:0] b4,
                           input logic [31:0] a8, input logic [31:0] b8);
        ra[0] = a4; rb[0] = b4;
        ra[1] = a4; rb[1] = b4;
        ra[2] = a8; rb[2] = b8;
    endtask

    task automatic set_ops_rand();
        set_ops($urandom & 32'hF, $urandom & 32'hF, $urandom & 32'hFF, $urandom & 32'hFF);
    endtask

    // stimulus
    initial begin : stim
        rst = 1'b0; start = 1'b0; fin_chk = 1'b0;
        set_ops(32'd0, 32'd0, 32'd0, 32'd0);
        tick(3);
        rst = 1'b1;
        tick(2);
        // multiplier 1101 on the 4-bit configs, FF x FF on the 8-bit one
        set_ops(32'd7, 32'd13, 32'hFF, 32'hFF);
        start = 1'b1; tick(1); start = 1'b0; tick(12);
        set_ops(32'd9, 32'd0, 32'h00, 32'hA5);
        start = 1'b1; tick(1); start = 1'b0; tick(12);
        repeat (12) begin
            set_ops_rand();
            start = 1'b1; tick(1); start = 1'b0;
            tick($urandom_range(1, 18));
        end
        // start held high: ignored while busy, re-accepted in DONE
        set_ops_rand();
        start = 1'b1; tick(30); start = 1'b0; tick(12);
        // reset mid-operation with start held through it
        set_ops_rand();
        start = 1'b1; tick(1); start = 1'b0; tick(3);
        start = 1'b1; rst = 1'b0; tick(1);
        rst = 1'b1; tick(1); start = 1'b0; tick(14);
        // reset glitch between edges has no effect
        set_ops_rand();
        start = 1'b1; tick(1); start = 1'b0; tick(2);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        tick(12);
        // start while reset is low stays idle
        rst = 1'b0; tick(2);
        start = 1'b1; tick(1);
        start = 1'b0; rst = 1'b1; tick(3);
        tick(20);
        fin_chk = 1'b1;
        tick(1);
        fin_chk = 1'b0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
